// File: rtl/resnet_output_packer_if.sv
// Packed-output bus: accelerator sample stream in, ready/valid packed words out.
// The packer drives the master side; the writeback consumer sits on the slave side.
interface resnet_output_packer_if #(
    parameter int DATA_W = 16,
    parameter int LANES  = 4
);
    logic                     hw_output_stencil_op_hcompute_hw_output_stencil_write_valid;
    logic [DATA_W-1:0]        hw_output_stencil_op_hcompute_hw_output_stencil_write;
    logic                     m_valid;
    logic                     m_ready;
    logic [DATA_W*LANES-1:0]  m_data;
    logic                     m_last;

    modport master (
        input  hw_output_stencil_op_hcompute_hw_output_stencil_write_valid,
        input  hw_output_stencil_op_hcompute_hw_output_stencil_write,
        input  m_ready,
        output m_valid,
        output m_data,
        output m_last
    );

    modport slave (
        output hw_output_stencil_op_hcompute_hw_output_stencil_write_valid,
        output hw_output_stencil_op_hcompute_hw_output_stencil_write,
        output m_ready,
        input  m_valid,
        input  m_data,
        input  m_last
    );
endinterface

// File: rtl/resnet_output_packer.sv
// Packs LANES accelerator samples per word into a first-word-fall-through FIFO,
// tracks the frame length, tags/pads the final word and reports completion/errors.
module resnet_output_packer #(
    parameter int DATA_W        = 16,
    parameter int LANES         = 4,
    parameter int DEPTH         = 8,
    parameter int TOTAL_OUTPUTS = 1024
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 flush,
    resnet_output_packer_if.master               bus,
    output logic                                 done,
    output logic                                 overflow,
    output logic                                 err_extra,
    output logic [$clog2(TOTAL_OUTPUTS+1)-1:0]   sample_count
);
    localparam int CW  = $clog2(TOTAL_OUTPUTS + 1);
    localparam int LIW = $clog2(LANES);
    localparam int AW  = $clog2(DEPTH);
    localparam int WW  = DATA_W * LANES;

    typedef enum logic [1:0] {COLLECT, DRAIN, DONE} state_e;

    state_e                         state_q, state_d;
    logic [LIW-1:0]                 lane_q, lane_d;
    logic [CW-1:0]                  count_q, count_d;
    logic [LANES-1:0][DATA_W-1:0]   pack_q, pack_d;
    logic [AW:0]                    wr_q, wr_d, rd_q, rd_d;
    logic                           overflow_q, overflow_d;
    logic                           err_q, err_d;

    logic [WW:0]                    fifo_mem [DEPTH];
    logic [WW:0]                    head;
    logic [WW-1:0]                  word;
    logic                           sample_valid, fire, is_final, push, pop, wr_en;
    logic                           empty, full;

    assign sample_valid = bus.hw_output_stencil_op_hcompute_hw_output_stencil_write_valid;
    assign fire         = sample_valid && !flush && (state_q == COLLECT);
    assign is_final     = (count_q == CW'(TOTAL_OUTPUTS - 1));
    assign push         = fire && ((lane_q == LIW'(LANES - 1)) || is_final);

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop   = !empty && bus.m_ready;
    // A full FIFO still accepts the word when the head leaves on the same edge.
    assign wr_en = push && (!full || pop);

    // Outgoing word: stored lanes below lane_q, the live sample at lane_q, zeros above.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign word[gi*DATA_W +: DATA_W] =
            (LIW'(gi) < lane_q)  ? pack_q[gi] :
            (LIW'(gi) == lane_q) ? bus.hw_output_stencil_op_hcompute_hw_output_stencil_write :
                                   '0;
    end

    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        count_d    = count_q;
        pack_d     = pack_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        overflow_d = overflow_q;
        err_d      = err_q;
        if (flush) begin
            state_d    = COLLECT;
            lane_d     = '0;
            count_d    = '0;
            pack_d     = '0;
            wr_d       = '0;
            rd_d       = '0;
            overflow_d = 1'b0;
            err_d      = 1'b0;
        end else begin
            if (fire) begin
                pack_d[lane_q] = bus.hw_output_stencil_op_hcompute_hw_output_stencil_write;
                count_d        = count_q + 1'b1;
                lane_d         = push ? '0 : lane_q + 1'b1;
            end
            if (wr_en) wr_d = wr_q + 1'b1;
            if (pop)   rd_d = rd_q + 1'b1;
            if (push && !wr_en) overflow_d = 1'b1;
            if (sample_valid && (state_q != COLLECT)) err_d = 1'b1;
            case (state_q)
                COLLECT: if (push && is_final) state_d = DRAIN;
                // Looking at the post-edge pointers makes done rise right after the final pop.
                DRAIN:   if (wr_d == rd_d) state_d = DONE;
                default: state_d = DONE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= COLLECT;
            lane_q     <= '0;
            count_q    <= '0;
            pack_q     <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            overflow_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            count_q    <= count_d;
            pack_q     <= pack_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            overflow_q <= overflow_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !flush) fifo_mem[wr_q[AW-1:0]] <= {is_final, word};
    end

    assign head         = fifo_mem[rd_q[AW-1:0]];
    assign bus.m_valid  = !empty;
    assign bus.m_data   = empty ? '0 : head[WW-1:0];
    assign bus.m_last   = !empty && head[WW];
    assign done         = (state_q == DONE);
    assign overflow     = overflow_q;
    assign err_extra    = err_q;
    assign sample_count = count_q;
endmodule

// File: tb/tb_resnet_output_packer.sv
// Bench for resnet_output_packer: scoreboarded full-size frames plus a
// vector table on a 10-sample instance for the partial-final-word case.
module tb_resnet_output_packer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    resnet_output_packer_if #(.DATA_W(16), .LANES(4)) ifa ();
    resnet_output_packer_if #(.DATA_W(16), .LANES(4)) ifb ();

    logic        done_a, ovf_a, err_a, done_b, ovf_b, err_b;
    logic [10:0] sc_a;
    logic [3:0]  sc_b;

    resnet_output_packer #(.DATA_W(16), .LANES(4), .DEPTH(8), .TOTAL_OUTPUTS(1024)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(ifa.master),
        .done(done_a), .overflow(ovf_a), .err_extra(err_a), .sample_count(sc_a));

    resnet_output_packer #(.DATA_W(16), .LANES(4), .DEPTH(8), .TOTAL_OUTPUTS(10)) u_small (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(ifb.master),
        .done(done_b), .overflow(ovf_b), .err_extra(err_b), .sample_count(sc_b));

    int checks = 0;
    int errors = 0;

    typedef struct { logic [63:0] data; logic last; } exp_t;
    exp_t        exp_q[$];
    logic [63:0] m_word;
    int          m_lane, m_cnt, word_idx, drop_after;
    int          words_seen;
    logic [63:0] first_word, last_word;
    logic        last_seen;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_word = '0; m_lane = 0; m_cnt = 0; word_idx = 0; drop_after = 1 << 30;
        words_seen = 0; first_word = '0; last_word = '0; last_seen = 1'b0;
    endtask

    // Drive one sample on the big instance and predict the word it completes.
    task automatic a_sample(input logic [15:0] d);
        ifa.hw_output_stencil_op_hcompute_hw_output_stencil_write_valid = 1'b1;
        ifa.hw_output_stencil_op_hcompute_hw_output_stencil_write       = d;
        if (m_cnt < 1024) begin
            m_word[m_lane*16 +: 16] = d;
            m_cnt++;
            if (m_lane == 3 || m_cnt == 1024) begin
                if (word_idx < drop_after) exp_q.push_back('{m_word, (m_cnt == 1024)});
                word_idx++;
                m_word = '0;
                m_lane = 0;
            end else begin
                m_lane++;
            end
        end
        @(posedge clk); #1;
        ifa.hw_output_stencil_op_hcompute_hw_output_stencil_write_valid = 1'b0;
    endtask

    task automatic a_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) a_sample(16'(i));
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget && !done_a; k++) begin
            @(posedge clk); #1;
        end
        check("done_rise", done_a, 1);
    endtask

    task automatic do_flush(input logic with_sample);
        flush = 1'b1;
        ifa.hw_output_stencil_op_hcompute_hw_output_stencil_write_valid = with_sample;
        ifa.hw_output_stencil_op_hcompute_hw_output_stencil_write       = 16'h5555;
        @(posedge clk); #1;
        flush = 1'b0;
        ifa.hw_output_stencil_op_hcompute_hw_output_stencil_write_valid = 1'b0;
        model_reset();
    endtask

    // Scoreboard: a word is consumed at the edge after a cycle with valid & ready.
    always @(negedge clk) begin
        if (rst_n && ifa.m_valid && ifa.m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL word_unexpected got %h last %b", ifa.m_data, ifa.m_last);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({ifa.m_last, ifa.m_data} !== {e.last, e.data}) begin
                    errors++;
                    $display("FAIL word%0d got %h last %b expected %h last %b",
                             words_seen, ifa.m_data, ifa.m_last, e.data, e.last);
                end
            end
            if (words_seen == 0) first_word = ifa.m_data;
            last_word = ifa.m_data;
            if (ifa.m_last) last_seen = 1'b1;
            words_seen++;
        end
    end

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        ev;
        logic [63:0] ed;
        logic        el;
        logic [3:0]  ec;
        logic        edone;
        logic        eerr;
    } vec_t;
    vec_t tbl [11];

    initial begin
        #1_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        ifa.hw_output_stencil_op_hcompute_hw_output_stencil_write_valid = 1'b0;
        ifa.hw_output_stencil_op_hcompute_hw_output_stencil_write       = '0;
        ifa.m_ready = 1'b1;
        ifb.hw_output_stencil_op_hcompute_hw_output_stencil_write_valid = 1'b0;
        ifb.hw_output_stencil_op_hcompute_hw_output_stencil_write       = '0;
        ifb.m_ready = 1'b1;
        model_reset();

        for (int i = 0; i < 10; i++) tbl[i] = '{1'b1, 16'(i + 1), 1'b0, 64'h0, 1'b0, 4'(i + 1), 1'b0, 1'b0};
        tbl[3].ev = 1'b1; tbl[3].ed = 64'h0004_0003_0002_0001;
        tbl[7].ev = 1'b1; tbl[7].ed = 64'h0008_0007_0006_0005;
        tbl[9].ev = 1'b1; tbl[9].ed = 64'h0000_0000_000A_0009; tbl[9].el = 1'b1;
        tbl[10]   = '{1'b1, 16'h00BB, 1'b0, 64'h0, 1'b0, 4'd10, 1'b1, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", ifa.m_valid, 0);
        check("rst_m_data", ifa.m_data, 0);
        check("rst_m_last", ifa.m_last, 0);
        check("rst_done", done_a, 0);
        check("rst_flags", {ovf_a, err_a}, 0);
        check("rst_count", sc_a, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Ten-sample frame: two full words, then a zero-padded final word.
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            ifb.hw_output_stencil_op_hcompute_hw_output_stencil_write_valid = tbl[i].v;
            ifb.hw_output_stencil_op_hcompute_hw_output_stencil_write       = tbl[i].d;
            @(posedge clk); #1;
            ifb.hw_output_stencil_op_hcompute_hw_output_stencil_write_valid = 1'b0;
            @(negedge clk);
            check($sformatf("b%0d_valid", i), ifb.m_valid, tbl[i].ev);
            check($sformatf("b%0d_data", i), ifb.m_data, tbl[i].ed);
            check($sformatf("b%0d_last", i), ifb.m_last, tbl[i].el);
            check($sformatf("b%0d_count", i), sc_b, tbl[i].ec);
            check($sformatf("b%0d_done", i), done_b, tbl[i].edone);
            check($sformatf("b%0d_err", i), err_b, tbl[i].eerr);
        end
        check("b_overflow", ovf_b, 0);

        // Full frame, consumer always ready.
        @(posedge clk); #1;
        a_range(1, 1024);
        wait_done(100);
        check("f1_words", words_seen, 256);
        check("f1_first", first_word, 64'h0004_0003_0002_0001);
        check("f1_lastword", last_word, 64'h0400_03FF_03FE_03FD);
        check("f1_last_seen", last_seen, 1);
        check("f1_flags", {ovf_a, err_a}, 0);
        check("f1_count", sc_a, 1024);

        // Samples after completion are dropped and flagged.
        a_range(2000, 2002);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("x_err", err_a, 1);
        check("x_count", sc_a, 1024);
        check("x_words", words_seen, 256);
        check("x_done", done_a, 1);
        check("x_m_valid", ifa.m_valid, 0);

        // Flush with a coincident sample clears everything and counts nothing.
        do_flush(1'b1);
        @(negedge clk);
        check("fl_done", done_a, 0);
        check("fl_flags", {ovf_a, err_a}, 0);
        check("fl_count", sc_a, 0);
        check("fl_m_valid", ifa.m_valid, 0);

        // Stalled consumer: first eight words fill the FIFO, the rest are lost.
        @(posedge clk); #1;
        ifa.m_ready = 1'b0;
        drop_after = 8;
        a_range(1, 32);
        @(negedge clk);
        check("ov_before", ovf_a, 0);
        check("ov_full_valid", ifa.m_valid, 1);
        a_range(33, 36);
        @(negedge clk);
        check("ov_after", ovf_a, 1);
        a_range(37, 1024);
        check("ov_count", sc_a, 1024);
        ifa.m_ready = 1'b1;
        wait_done(100);
        check("ov_words", words_seen, 8);
        check("ov_no_last", last_seen, 0);
        check("ov_queue_empty", exp_q.size(), 0);
        do_flush(1'b0);

        // Push into a full FIFO on the same edge as a pop: nothing is lost.
        ifa.m_ready = 1'b0;
        a_range(1, 35);
        ifa.m_ready = 1'b1;
        a_sample(16'd36);
        ifa.m_ready = 1'b0;
        @(negedge clk);
        check("pp_overflow", ovf_a, 0);
        check("pp_m_valid", ifa.m_valid, 1);
        ifa.m_ready = 1'b1;
        a_range(37, 1024);
        wait_done(100);
        check("pp_words", words_seen, 256);
        check("pp_overflow_end", ovf_a, 0);
        check("pp_last_seen", last_seen, 1);
        do_flush(1'b0);

        // Asynchronous reset with words queued.
        ifa.m_ready = 1'b0;
        a_range(1, 20);
        rst_n = 1'b0;
        #1;
        check("ar_m_valid", ifa.m_valid, 0);
        check("ar_m_data", ifa.m_data, 0);
        check("ar_count", sc_a, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        ifa.m_ready = 1'b1;
        a_range(1, 1024);
        wait_done(100);
        check("ar_words", words_seen, 256);
        check("ar_first", first_word, 64'h0004_0003_0002_0001);
        check("ar_flags", {ovf_a, err_a}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
